// File: rtl/dram_burst_responder.sv
// DRAM stand-in: accepts one burst request, acks it, waits a fixed latency,
// then streams len words from a preloadable backing SRAM.
module dram_burst_responder #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LAT_CYCLES = 4,
  parameter int unsigned MAX_LEN    = 256,
  localparam int unsigned MW_AW     = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dram_req,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [15:0]           dram_len,
  output logic                  dram_ack,
  output logic                  dram_data_valid,
  output logic [DATA_W-1:0]     dram_data_out,
  output logic                  busy,
  output logic                  error,
  input  logic                  preload_we,
  input  logic [MW_AW-1:0]      preload_addr,
  input  logic [DATA_W-1:0]     preload_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACK    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [7:0]  LAT_LAST  = 8'(LAT_CYCLES - 1);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [1:0]       state, state_nx;
  logic [7:0]       wait_cnt, wait_nx;
  logic [15:0]      beat_cnt, beat_nx;
  logic [15:0]      len_q, len_nx;
  logic [MW_AW-1:0] ptr, ptr_nx;
  logic             err_nx;
  logic             take_beat;

  // Upper request address bits do not select anything in the backing SRAM.
  logic addr_unused;
  assign addr_unused = ^dram_addr[ADDR_WIDTH-1:MW_AW];

  // Backing SRAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (preload_we) mem[preload_addr] <= preload_data;
  end

  // Next-state logic; take_beat fetches mem[ptr] into the output register.
  always_comb begin
    state_nx  = state;
    wait_nx   = wait_cnt;
    beat_nx   = beat_cnt;
    len_nx    = len_q;
    ptr_nx    = ptr;
    err_nx    = error;
    take_beat = 1'b0;
    case (state)
      S_IDLE: begin
        if (dram_req) begin
          state_nx = S_ACK;
          len_nx   = dram_len;
          ptr_nx   = dram_addr[MW_AW-1:0];
        end
      end
      S_ACK: begin
        if (len_q == 16'd0 || len_q > MAX_LEN_W) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else if (LAT_CYCLES > 0) begin
          state_nx = S_WAIT;
          wait_nx  = 8'd0;
        end else begin
          state_nx  = S_STREAM;
          take_beat = 1'b1;
          beat_nx   = 16'd1;
        end
      end
      S_WAIT: begin
        if (wait_cnt == LAT_LAST) begin
          state_nx  = S_STREAM;
          take_beat = 1'b1;
          beat_nx   = 16'd1;
        end else begin
          wait_nx = wait_cnt + 8'd1;
        end
      end
      S_STREAM: begin
        if (beat_cnt == len_q) begin
          state_nx = S_IDLE;
          beat_nx  = 16'd0;
        end else begin
          take_beat = 1'b1;
          beat_nx   = beat_cnt + 16'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (take_beat) ptr_nx = ptr + MW_AW'(1);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      wait_cnt        <= 8'd0;
      beat_cnt        <= 16'd0;
      len_q           <= 16'd0;
      ptr             <= '0;
      dram_ack        <= 1'b0;
      dram_data_valid <= 1'b0;
      dram_data_out   <= '0;
      busy            <= 1'b0;
      error           <= 1'b0;
    end else begin
      state           <= state_nx;
      wait_cnt        <= wait_nx;
      beat_cnt        <= beat_nx;
      len_q           <= len_nx;
      ptr             <= ptr_nx;
      dram_ack        <= (state_nx == S_ACK);
      dram_data_valid <= take_beat;
      busy            <= (state_nx != S_IDLE);
      error           <= err_nx;
      if (take_beat) dram_data_out <= mem[ptr];
    end
  end

endmodule

// File: tb/tb_dram_burst_responder.sv
// Directed bench for dram_burst_responder: burst timing, wrap, illegal lengths,
// back-to-back requests, preload collisions and mid-burst reset.
module tb_dram_burst_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        dram_req;
  logic [31:0] dram_addr;
  logic [15:0] dram_len;
  logic        dram_ack;
  logic        dram_data_valid;
  logic [15:0] dram_data_out;
  logic        busy;
  logic        error;
  logic        preload_we;
  logic [9:0]  preload_addr;
  logic [15:0] preload_data;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_ack, n_beat, idle_k;
  int          ack_k  [2];
  int          beat_k [64];
  logic [15:0] beat_d [64];

  always #5 clk = ~clk;

  dram_burst_responder dut (
    .clk(clk), .rst(rst),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_len(dram_len),
    .dram_ack(dram_ack), .dram_data_valid(dram_data_valid),
    .dram_data_out(dram_data_out), .busy(busy), .error(error),
    .preload_we(preload_we), .preload_addr(preload_addr), .preload_data(preload_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and observe ncyc cycles after the sampling edge.
  // mode 1: req pulse during WAIT; mode 2: preload writes mid-burst; mode 3: req held.
  task automatic run_burst(input logic [31:0] a, input logic [15:0] l, input int mode, input int ncyc);
    n_ack = 0; n_beat = 0; idle_k = -1; ack_k[0] = -1; ack_k[1] = -1;
    @(negedge clk);
    dram_addr = a; dram_len = l; dram_req = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (dram_ack) begin
        if (n_ack < 2) ack_k[n_ack] = k;
        n_ack++;
      end
      if (dram_data_valid && n_beat < 64) begin
        beat_k[n_beat] = k;
        beat_d[n_beat] = dram_data_out;
        n_beat++;
      end
      if (!busy && idle_k < 0) idle_k = k;
      if (mode == 3) begin
        if (n_ack == 2) dram_req = 1'b0;
      end else if (k == 1) begin
        dram_req = 1'b0;
      end
      if (mode == 1 && k == 3) dram_req = 1'b1;
      if (mode == 1 && k == 4) dram_req = 1'b0;
      if (mode == 2 && k == 8) begin
        preload_we = 1'b1; preload_addr = 10'd6; preload_data = 16'hBEEF;
      end
      if (mode == 2 && k == 9) begin
        preload_addr = 10'd3; preload_data = 16'h1234;
      end
      if (mode == 2 && k == 10) preload_we = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; dram_req = 1'b0; dram_addr = '0; dram_len = '0;
    preload_we = 1'b0; preload_addr = '0; preload_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(dram_ack), 32'd0);
    check("rst_valid", 32'(dram_data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data", 32'(dram_data_out), 32'd0);
    rst = 1'b0;

    // mem[i] = 0x0100 + i across the whole SRAM
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      preload_we = 1'b1; preload_addr = 10'(i); preload_data = 16'h0100 + 16'(i);
    end
    @(negedge clk);
    preload_we = 1'b0;

    // Basic burst, LAT=4
    run_burst(32'd2, 16'd4, 0, 14);
    check("t1_ack_cnt", 32'(n_ack), 32'd1);
    check("t1_ack_cyc", 32'(ack_k[0]), 32'd1);
    check("t1_beats", 32'(n_beat), 32'd4);
    check("t1_first_cyc", 32'(beat_k[0]), 32'd6);
    check("t1_last_cyc", 32'(beat_k[3]), 32'd9);
    check("t1_d0", 32'(beat_d[0]), 32'h0102);
    check("t1_d1", 32'(beat_d[1]), 32'h0103);
    check("t1_d2", 32'(beat_d[2]), 32'h0104);
    check("t1_d3", 32'(beat_d[3]), 32'h0105);
    check("t1_idle_cyc", 32'(idle_k), 32'd10);

    // Address wrap
    run_burst(32'd1022, 16'd4, 0, 14);
    check("t2_beats", 32'(n_beat), 32'd4);
    check("t2_d0", 32'(beat_d[0]), 32'h04FE);
    check("t2_d1", 32'(beat_d[1]), 32'h04FF);
    check("t2_d2", 32'(beat_d[2]), 32'h0100);
    check("t2_d3", 32'(beat_d[3]), 32'h0101);
    check("t2_error", 32'(error), 32'd0);

    // Illegal lengths
    run_burst(32'd0, 16'd0, 0, 8);
    check("t3a_ack_cnt", 32'(n_ack), 32'd1);
    check("t3a_beats", 32'(n_beat), 32'd0);
    check("t3a_idle_cyc", 32'(idle_k), 32'd2);
    check("t3a_error", 32'(error), 32'd1);
    run_burst(32'd0, 16'd257, 0, 8);
    check("t3b_ack_cnt", 32'(n_ack), 32'd1);
    check("t3b_beats", 32'(n_beat), 32'd0);
    check("t3b_error", 32'(error), 32'd1);
    run_burst(32'd5, 16'd3, 0, 12);
    check("t3c_beats", 32'(n_beat), 32'd3);
    check("t3c_d0", 32'(beat_d[0]), 32'h0105);
    check("t3c_d2", 32'(beat_d[2]), 32'h0107);
    check("t3c_error", 32'(error), 32'd1);

    // Back-to-back with req held, then a req pulse during WAIT
    run_burst(32'd0, 16'd2, 3, 20);
    check("t4_ack_cnt", 32'(n_ack), 32'd2);
    check("t4_ack_gap", 32'(ack_k[1] - ack_k[0]), 32'd8);
    check("t4_beats", 32'(n_beat), 32'd4);
    run_burst(32'd0, 16'd2, 1, 15);
    check("t4_wait_ack_cnt", 32'(n_ack), 32'd1);
    check("t4_wait_beats", 32'(n_beat), 32'd2);

    // Preload during a burst: later word sees new data, same-cycle word sees old
    run_burst(32'd0, 16'd8, 2, 16);
    check("t6_beats", 32'(n_beat), 32'd8);
    check("t6_d3_old", 32'(beat_d[3]), 32'h0103);
    check("t6_d6_new", 32'(beat_d[6]), 32'hBEEF);
    check("t6_d7", 32'(beat_d[7]), 32'h0107);

    // Reset during beat 2 of an 8-beat burst
    @(negedge clk);
    dram_addr = 32'd0; dram_len = 16'd8; dram_req = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) dram_req = 1'b0;
    end
    check("t5_valid_before", 32'(dram_data_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_valid_async", 32'(dram_data_valid), 32'd0);
    check("t5_busy_async", 32'(busy), 32'd0);
    check("t5_error_cleared", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_burst(32'd0, 16'd1, 0, 10);
    check("t5_ack_cnt", 32'(n_ack), 32'd1);
    check("t5_beats", 32'(n_beat), 32'd1);
    check("t5_beat_cyc", 32'(beat_k[0]), 32'd6);
    check("t5_d0", 32'(beat_d[0]), 32'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
